// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: PS/2 keys and two pads to active-low arcade controls with coin pulse shaping
// Optional feature: define AUTO_COIN_EN so a start press also requests a coin on the same slot.
module arcade_input_mapper #(
  parameter int COIN_PULSE = 2400000,
  parameter int COIN_GAP   = 2400000
) (
  input  logic        CLK_IN,
  input  logic        I_RESET_N,
  input  logic [10:0] I_PS2_KEY,
  input  logic [15:0] I_JOY0,
  input  logic [15:0] I_JOY1,
  output logic [1:0]  O_COIN_S,
  output logic [1:0]  O_FIRE_S,
  output logic [1:0]  O_BOMB_S,
  output logic [1:0]  O_SELECT_S,
  output logic [1:0]  O_UP_S,
  output logic [1:0]  O_DOWN_S,
  output logic [1:0]  O_LEFT_S,
  output logic [1:0]  O_RIGHT_S,
  output logic        O_TEST
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [23:0] PULSE_LD = 24'(COIN_PULSE - 1);
  localparam logic [23:0] GAP_LD   = 24'(COIN_GAP - 1);
  // Latch index i answers to scancode CODES[i*8 +: 8]; indices 0..3 are the arrows, which ignore the extended flag.
  localparam logic [151:0] CODES = {8'h2C, 8'h1B, 8'h1C, 8'h34, 8'h23, 8'h2B, 8'h2D, 8'h36, 8'h2E, 8'h1E,
                                    8'h06, 8'h16, 8'h05, 8'h29, 8'h14, 8'h74, 8'h6B, 8'h72, 8'h75};
  logic        tog_q;
  logic        key_evt;
  logic [18:0] keys;
  logic [18:0] hit;
  logic        start1;
  logic        start2;
  logic [1:0]  req;
  logic [1:0]  req_q;
  logic [1:0]  state [2];
  logic [23:0] cnt [2];
  logic        unused_joy;
  assign unused_joy = ^{I_JOY0[15:9], I_JOY1[15:9]};
  assign key_evt = I_PS2_KEY[10] ^ tog_q;
  genvar i;
  generate
    for (i = 0; i < 19; i++) begin : g_hit
      assign hit[i] = (I_PS2_KEY[7:0] == CODES[i*8 +: 8]) && ((i < 4) ? 1'b1 : !I_PS2_KEY[8]);
    end
  endgenerate
  assign start1 = keys[6] | keys[7] | I_JOY0[6] | I_JOY1[6];
  assign start2 = keys[8] | keys[9] | I_JOY0[7] | I_JOY1[7];
`ifdef AUTO_COIN_EN
  assign req = {keys[11] | I_JOY1[8] | start2, keys[10] | I_JOY0[8] | start1};
`else
  assign req = {keys[11] | I_JOY1[8], keys[10] | I_JOY0[8]};
`endif
  // Track the toggle bit and load the addressed key latch with the pressed flag on each key event.
  always_ff @(posedge CLK_IN) begin
    tog_q <= I_PS2_KEY[10];
    if (!I_RESET_N)
      keys <= '0;
    else if (key_evt)
      keys <= (keys & ~hit) | (hit & {19{I_PS2_KEY[9]}});
  end
  // Remember last coin requests; reset high so a request held through reset must drop before it counts.
  always_ff @(posedge CLK_IN)
    req_q <= !I_RESET_N ? 2'b11 : req;
  // Per-slot coin sequencer: a rising request starts a fixed pulse followed by a dead gap; edges meanwhile are dropped.
  always_ff @(posedge CLK_IN)
    for (int s = 0; s < 2; s++)
      if (!I_RESET_N) begin
        state[s] <= IDLE;
        cnt[s]   <= '0;
      end else if (state[s] == IDLE) begin
        if (req[s] && !req_q[s]) begin
          state[s] <= PULSE;
          cnt[s]   <= PULSE_LD;
        end
      end else if (cnt[s] == '0) begin
        state[s] <= (state[s] == PULSE) ? GAP : IDLE;
        cnt[s]   <= (state[s] == PULSE) ? GAP_LD : '0;
      end else begin
        cnt[s] <= cnt[s] - 24'd1;
      end
  // Registered active-low controls: key latches ORed with the matching pad bits.
  always_ff @(posedge CLK_IN)
    if (!I_RESET_N) begin
      O_COIN_S   <= 2'b11;
      O_FIRE_S   <= 2'b11;
      O_BOMB_S   <= 2'b11;
      O_SELECT_S <= 2'b11;
      O_UP_S     <= 2'b11;
      O_DOWN_S   <= 2'b11;
      O_LEFT_S   <= 2'b11;
      O_RIGHT_S  <= 2'b11;
      O_TEST     <= 1'b0;
    end else begin
      O_COIN_S   <= ~{state[1] == PULSE, state[0] == PULSE};
      O_FIRE_S   <= ~{keys[16] | I_JOY1[4], keys[4] | I_JOY0[4]};
      O_BOMB_S   <= ~{keys[17] | I_JOY1[5], keys[5] | I_JOY0[5]};
      O_SELECT_S <= ~{start2, start1};
      O_UP_S     <= ~{keys[12] | I_JOY1[3], keys[0] | I_JOY0[3]};
      O_DOWN_S   <= ~{keys[13] | I_JOY1[2], keys[1] | I_JOY0[2]};
      O_LEFT_S   <= ~{keys[14] | I_JOY1[1], keys[2] | I_JOY0[1]};
      O_RIGHT_S  <= ~{keys[15] | I_JOY1[0], keys[3] | I_JOY0[0]};
      O_TEST     <= keys[18];
    end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed stimulus checked against a per-cycle reference model and literal expectations
module tb_arcade_input_mapper;
  localparam int P = 4;
  localparam int G = 3;
`ifdef AUTO_COIN_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] key = 11'h400;
  logic [15:0] joy0 = '0;
  logic [15:0] joy1 = '0;
  logic [1:0]  coin_s, fire_s, bomb_s, sel_s, up_s, down_s, left_s, right_s;
  logic        test;
  int n_chk = 0;
  int n_fail = 0;
  int lows;

  arcade_input_mapper #(.COIN_PULSE(P), .COIN_GAP(G)) dut (
    .CLK_IN(clk), .I_RESET_N(rst_n), .I_PS2_KEY(key), .I_JOY0(joy0), .I_JOY1(joy1),
    .O_COIN_S(coin_s), .O_FIRE_S(fire_s), .O_BOMB_S(bomb_s), .O_SELECT_S(sel_s),
    .O_UP_S(up_s), .O_DOWN_S(down_s), .O_LEFT_S(left_s), .O_RIGHT_S(right_s), .O_TEST(test)
  );

  always #5 clk = ~clk;

  // Reference model: pressed state per scancode, coin pulses as time windows on a cycle counter.
  bit [255:0] kp;
  bit         tog_m;
  bit [1:0]   req_m, req_prev;
  bit         s1, s2;
  int         cyc = 0;
  int         free_at [2];
  int         lo_from [2];
  int         lo_to [2];
  logic [1:0] e_coin, e_fire, e_bomb, e_sel, e_up, e_down, e_left, e_right;
  logic       e_test;
  bit         model_ok = 1'b0;

  function automatic bit is_arrow(input logic [7:0] c);
    return c == 8'h75 || c == 8'h72 || c == 8'h6B || c == 8'h74;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      kp = '0;
      tog_m = key[10];
      req_prev = 2'b11;
      for (int s = 0; s < 2; s++) begin
        free_at[s] = 0;
        lo_from[s] = 0;
        lo_to[s] = -1;
      end
      {e_coin, e_fire, e_bomb, e_sel, e_up, e_down, e_left, e_right} = '1;
      e_test = 1'b0;
    end else begin
      s1 = kp[8'h05] | kp[8'h16] | joy0[6] | joy1[6];
      s2 = kp[8'h06] | kp[8'h1E] | joy0[7] | joy1[7];
      e_fire  = ~{kp[8'h1C] | joy1[4], kp[8'h14] | joy0[4]};
      e_bomb  = ~{kp[8'h1B] | joy1[5], kp[8'h29] | joy0[5]};
      e_sel   = ~{s2, s1};
      e_up    = ~{kp[8'h2D] | joy1[3], kp[8'h75] | joy0[3]};
      e_down  = ~{kp[8'h2B] | joy1[2], kp[8'h72] | joy0[2]};
      e_left  = ~{kp[8'h23] | joy1[1], kp[8'h6B] | joy0[1]};
      e_right = ~{kp[8'h34] | joy1[0], kp[8'h74] | joy0[0]};
      e_test  = kp[8'h2C];
      req_m[0] = kp[8'h2E] | joy0[8] | (AUTO & s1);
      req_m[1] = kp[8'h36] | joy1[8] | (AUTO & s2);
      for (int s = 0; s < 2; s++) begin
        if (req_m[s] && !req_prev[s] && cyc >= free_at[s]) begin
          lo_from[s] = cyc + 1;
          lo_to[s]   = cyc + P;
          free_at[s] = cyc + P + G + 1;
        end
        e_coin[s] = !(cyc >= lo_from[s] && cyc <= lo_to[s]);
      end
      req_prev = req_m;
      if (key[10] != tog_m && (is_arrow(key[7:0]) || !key[8]))
        kp[key[7:0]] = key[9];
      tog_m = key[10];
    end
    model_ok = 1'b1;
  end

  // Every cycle, compare all DUT outputs with the model.
  always @(negedge clk)
    if (model_ok) begin
      n_chk++;
      if ({coin_s, fire_s, bomb_s, sel_s, up_s, down_s, left_s, right_s, test} !==
          {e_coin, e_fire, e_bomb, e_sel, e_up, e_down, e_left, e_right, e_test}) begin
        n_fail++;
        $display("FAIL model_cmp cycle %0d: got %h expected %h", cyc,
                 {coin_s, fire_s, bomb_s, sel_s, up_s, down_s, left_s, right_s, test},
                 {e_coin, e_fire, e_bomb, e_sel, e_up, e_down, e_left, e_right, e_test});
      end
    end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_cnt();
    step();
    if (coin_s == 2'b10) lows++;
  endtask

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("idle_coin", 8'(coin_s), 8'h3);
    chk("idle_fire", 8'(fire_s), 8'h3);
    chk("idle_bomb", 8'(bomb_s), 8'h3);
    chk("idle_sel", 8'(sel_s), 8'h3);
    chk("idle_up", 8'(up_s), 8'h3);
    chk("idle_down", 8'(down_s), 8'h3);
    chk("idle_left", 8'(left_s), 8'h3);
    chk("idle_right", 8'(right_s), 8'h3);
    chk("idle_test", 8'(test), 8'h0);
    key = 11'h475;
    step();
    chk("no_event_up", 8'(up_s), 8'h3);
    key = 11'h375;
    step();
    chk("up_latency", 8'(up_s), 8'h3);
    step();
    chk("up_press", 8'(up_s), 8'h2);
    key = 11'h575;
    step();
    step();
    chk("up_release", 8'(up_s), 8'h3);
    joy0 = 16'h0100;
    lows = 0;
    step();
    chk("joy_coin_latency", 8'(coin_s), 8'h3);
    repeat (19) step_cnt();
    chk("joy_coin_len", 8'(lows), 8'd4);
    joy0 = '0;
    repeat (10) step();
    lows = 0;
    key = 11'h22E;
    step_cnt();
    key = 11'h42E;
    repeat (5) step_cnt();
    key = 11'h22E;
    repeat (14) step_cnt();
    chk("key_coin_gap_drop", 8'(lows), 8'd4);
    key = 11'h42E;
    repeat (10) step();
    joy0 = 16'h0100;
    joy1 = 16'h0100;
    step();
    step();
    chk("coin_both", 8'(coin_s), 8'h0);
    step();
    chk("coin_both_hold", 8'(coin_s), 8'h0);
    rst_n = 1'b0;
    step();
    chk("coin_abort", 8'(coin_s), 8'h3);
    rst_n = 1'b1;
    repeat (6) step();
    chk("held_req_no_retrigger", 8'(coin_s), 8'h3);
    joy0 = '0;
    joy1 = '0;
    repeat (8) step();
    key = 11'h216;
    step();
    step();
    chk("start1_sel", 8'(sel_s), 8'h2);
    lows = 0;
    repeat (10) step_cnt();
    chk("start1_auto_coin", 8'(lows), AUTO ? 8'd4 : 8'd0);
    key = 11'h416;
    repeat (10) step();
    key = 11'h32D;
    step();
    step();
    chk("ext_nonarrow_ignored", 8'(up_s), 8'h3);
    key = 11'h62D;
    step();
    step();
    chk("p2_up", 8'(up_s), 8'h1);
    key = 11'h22C;
    step();
    step();
    chk("test_on", 8'(test), 8'h1);
    key = 11'h42C;
    step();
    step();
    chk("test_off", 8'(test), 8'h0);
    joy1 = 16'h0010;
    step();
    chk("p2_fire_joy", 8'(fire_s), 8'h1);
    joy0 = 16'h0003;
    step();
    chk("socd_left", 8'(left_s), 8'h2);
    chk("socd_right", 8'(right_s), 8'h2);
    joy1 = 16'h0080;
    step();
    chk("start2_joy", 8'(sel_s), 8'h1);
    joy0 = '0;
    joy1 = '0;
    repeat (12) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/arcade_input_mapper.md
ARCADE_INPUT_MAPPER -- requirements
Module: arcade_input_mapper

Interface
REQ-001 Parameter COIN_PULSE, default 2400000, coin line hold time in CLK_IN cycles (legal 1..16777215).
REQ-002 Parameter COIN_GAP, default 2400000, minimum coin-line release time after a pulse in CLK_IN cycles (legal 1..16777215).
REQ-003 CLK_IN  in  1  system clock; the only clock in the block.
REQ-004 I_RESET_N  in  1  synchronous reset, active-low.
REQ-005 I_PS2_KEY  in  11  keyboard event: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
REQ-006 I_JOY0, I_JOY1  in  16 each  player 1/2 pad: [0] right, [1] left, [2] down, [3] up, [4] fire, [5] bomb, [6] start1, [7] start2, [8] coin.
REQ-007 O_COIN_S, O_FIRE_S, O_BOMB_S, O_SELECT_S, O_UP_S, O_DOWN_S, O_LEFT_S, O_RIGHT_S  out  2 each  active-low controls; bit 0 player/slot 1, bit 1 player/slot 2.
REQ-008 O_TEST  out  1  active-high service/test.

Function
REQ-009 Key event = I_PS2_KEY[10] differs from its value registered on the previous edge; on that edge the matching key latch loads I_PS2_KEY[9].
REQ-010 Arrows 0x75/0x72/0x6B/0x74 -> P1 up/down/left/right, matched with bit 8 ignored; all other codes require bit 8 = 0.
REQ-011 0x14 P1 fire; 0x29 P1 bomb; 0x05 and 0x16 start1; 0x06 and 0x1E start2; 0x2E coin1; 0x36 coin2; 0x2D/0x2B/0x23/0x34 P2 up/down/left/right; 0x1C P2 fire; 0x1B P2 bomb; 0x2C test; unlisted codes ignored.
REQ-012 Each control = OR of its key latch(es) and the corresponding I_JOY0 (player 1) or I_JOY1 (player 2) bit; start1/start2 also OR both pads' [6]/[7].
REQ-013 All outputs registered; latency 2 edges from the key-event edge, 1 edge from a joystick bit change (outputs update on the edge after the source changes).
REQ-014 Opposing directions pass through unmodified (no SOCD cleaning).
REQ-015 Coin request per slot: slot1 = coin1 latch | I_JOY0[8]; slot2 = coin2 latch | I_JOY1[8].
REQ-016 Per-slot coin FSM, states IDLE, PULSE, GAP, 24-bit down-counter.
REQ-017 IDLE -> PULSE on rising edge of the slot request; counter loads COIN_PULSE-1.
REQ-018 PULSE: decrement; at 0 -> GAP with counter loading COIN_GAP-1.
REQ-019 GAP: decrement; at 0 -> IDLE.
REQ-020 O_COIN_S bit low exactly while the slot's FSM is in PULSE (delayed by one register), i.e. exactly COIN_PULSE cycles per accepted request.
REQ-021 Rising edges during PULSE or GAP are dropped, not queued; a request held high across GAP->IDLE does not retrigger.
REQ-022 Slots independent; simultaneous requests on both slots each produce a full pulse.

Reset
REQ-023 While I_RESET_N = 0 on an edge: all key latches 0, FSMs IDLE, counters 0, all _S outputs 2'b11, O_TEST 0.
REQ-024 During reset the toggle register loads I_PS2_KEY[10], so no event is generated on the first edge after release.
REQ-025 Coin request edge registers reset to 1, so a request held through reset must be released before it is accepted.
REQ-026 Reset asserted mid-pulse aborts the pulse; O_COIN_S returns to 1 on the next edge.

Configuration
REQ-027 Macro AUTO_COIN_EN: when defined, slot1 request additionally ORs start1 and slot2 ORs start2 (start press also inserts a coin); when undefined, coins come only from coin keys and pad bit [8].

Verification (COIN_PULSE=4, COIN_GAP=3)
REQ-028 Reset with I_PS2_KEY=11'h400 held, release, hold 5 edges -> all _S = 2'b11, O_TEST = 0, no event.
REQ-029 Toggle with {1,0,0x75} then {0,1,0x175} -> O_UP_S = 2'b10 two edges after the second event; key release -> 2'b11.
REQ-030 I_JOY0[8] 0->1 held 20 cycles -> O_COIN_S = 2'b10 for exactly 4 cycles, then 2'b11; no second pulse.
REQ-031 Coin key 0x2E pressed, released, pressed again 5 cycles later (during GAP) -> single 4-cycle pulse only.
REQ-032 I_JOY0[8] and I_JOY1[8] rise same edge -> O_COIN_S = 2'b00 for 4 cycles; reset asserted at cycle 2 -> 2'b11 next edge.
REQ-033 Key 0x16 pressed -> O_SELECT_S = 2'b10; with AUTO_COIN_EN also one 4-cycle O_COIN_S = 2'b10 pulse, without it none.
